// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-library types and constants
package arith_pkg;

  localparam int ARITH_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor (a - b - bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with start/done handshake
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             V
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             bw;
  logic             d_bit, bw_next;
  logic [WIDTH-1:0] next_res;
  logic             last;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bw),
    .d    (d_bit),
    .bout (bw_next)
  );

  // Result builds from the top down; the WIDTH-th bit goes straight to Diff.
  assign next_res = {d_bit, res_sh};
  assign last     = (cnt == CW'(WIDTH - 1));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      bw     <= 1'b0;
      Diff   <= '0;
      Bout   <= 1'b0;
      V      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            bw     <= Bin;
            cnt    <= '0;
            res_sh <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          bw     <= bw_next;
          res_sh <= next_res[WIDTH-1:1];
          cnt    <= cnt + CW'(1);
          // On the last bit a_sh[0]/b_sh[0] are the operand MSBs.
          if (last) begin
            Diff <= next_res;
            Bout <= bw_next;
            V    <= (a_sh[0] ^ b_sh[0]) & (d_bit ^ a_sh[0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
